// File: rtl/axi4s_trim_to_length_if.sv
// AXI4-Stream bundle used on both sides of axi4s_trim_to_length.
//   tdata  : WIDTH-bit data, byte 0 in [7:0]
//   tuser  : on the tlast beat, valid byte count (0 = all bytes valid); 0 otherwise
//   tlast  : end of packet
//   tvalid : source has a beat
//   tready : sink accepts the beat
// Modports: master drives payload/valid, slave drives ready.
interface axi4s_trim_to_length_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UWIDTH = $clog2(WIDTH/8+1)
) ();
  logic [WIDTH-1:0]  tdata;
  logic [UWIDTH-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axi4s_trim_to_length.sv
// Truncates each packet to the length given by a 16-bit big-endian field
// found LEN_OFFSET bytes into the packet (plus LEN_ADJUST), discarding any
// trailing MAC padding so tuser reports the true final byte count.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   upstream     : input stream (i_tdata/i_tuser/i_tlast/i_tvalid/i_tready)
//   downstream   : output stream (o_tdata/o_tuser/o_tlast/o_tvalid/o_tready),
//                  one-deep registered, 1-cycle latency
// Optional: define AXI4S_TRIM_TO_LENGTH_STATS_EN to add saturating 16-bit
//   trim_count / short_count outputs.
module axi4s_trim_to_length #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LEN_OFFSET = 2,
  parameter int          LEN_ADJUST = 0,
  parameter int unsigned UWIDTH     = $clog2(WIDTH/8+1)
) (
  input  logic clk,
  input  logic reset_n,
  axi4s_trim_to_length_if.slave  upstream,
  axi4s_trim_to_length_if.master downstream
`ifdef AXI4S_TRIM_TO_LENGTH_STATS_EN
  ,
  output logic [15:0] trim_count,
  output logic [15:0] short_count
`endif
);

  localparam int unsigned BYTES    = WIDTH / 8;
  localparam int unsigned WW       = 14;
  localparam int unsigned MSB_WORD = LEN_OFFSET / BYTES;
  localparam int unsigned LSB_WORD = (LEN_OFFSET + 1) / BYTES;
  localparam int unsigned MSB_LANE = LEN_OFFSET % BYTES;
  localparam int unsigned LSB_LANE = (LEN_OFFSET + 1) % BYTES;
  localparam int unsigned T_MIN    = LEN_OFFSET + 2;
  localparam bit          STRADDLE = (MSB_WORD != LSB_WORD);
  localparam logic [WW-1:0] W_MAX  = '1;

  typedef enum logic {PASS, DROP} state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     w_q, w_d;
  logic              len_valid_q, len_valid_d;
  logic [15:0]       end_q, end_d;
  logic [UWIDTH-1:0] rem_q, rem_d;
  logic [7:0]        msb_q, msb_d;
  logic              dv_q, dv_d, dl_q, dl_d;
  logic [WIDTH-1:0]  dd_q, dd_d;
  logic [UWIDTH-1:0] du_q, du_d;
  logic              trim_inc, short_inc;

  // Length field decode: T = clamp(field + LEN_ADJUST), E = last word, R = bytes in it
  logic [7:0]         fmsb, flsb;
  logic signed [17:0] t_raw;
  logic [15:0]        t_len, e_c;
  logic [UWIDTH-1:0]  r_c;

  assign fmsb  = STRADDLE ? msb_q : upstream.tdata[MSB_LANE*8 +: 8];
  assign flsb  = upstream.tdata[LSB_LANE*8 +: 8];
  assign t_raw = $signed({2'b00, fmsb, flsb}) + $signed(18'(LEN_ADJUST));

  always_comb begin
    if (t_raw < $signed(18'(T_MIN)))  t_len = 16'(T_MIN);
    else if (t_raw > 18'sd65535)      t_len = 16'hFFFF;
    else                              t_len = t_raw[15:0];
  end

  assign e_c = (t_len - 16'd1) / 16'(BYTES);
  assign r_c = UWIDTH'(t_len % 16'(BYTES));

  // On the LSB beat the freshly decoded length is used directly, since E may equal that word
  logic              at_lsb, at_msb, at_end, in_fire;
  logic [15:0]       cur_e;
  logic [UWIDTH-1:0] cur_r, n_c;

  assign at_lsb  = (w_q == WW'(LSB_WORD));
  assign at_msb  = (w_q == WW'(MSB_WORD));
  assign cur_e   = len_valid_q ? end_q : e_c;
  assign cur_r   = len_valid_q ? rem_q : r_c;
  assign at_end  = (len_valid_q || at_lsb) && ({2'b00, w_q} == cur_e);
  assign n_c     = (upstream.tuser == '0) ? UWIDTH'(BYTES) : upstream.tuser;
  assign in_fire = upstream.tvalid && upstream.tready;

  assign upstream.tready   = (state_q == DROP) || !dv_q || downstream.tready;
  assign downstream.tvalid = dv_q;
  assign downstream.tdata  = dd_q;
  assign downstream.tuser  = du_q;
  assign downstream.tlast  = dl_q;

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    len_valid_d = len_valid_q;
    end_d       = end_q;
    rem_d       = rem_q;
    msb_d       = msb_q;
    dv_d        = dv_q;
    dd_d        = dd_q;
    du_d        = du_q;
    dl_d        = dl_q;
    trim_inc    = 1'b0;
    short_inc   = 1'b0;

    if (dv_q && downstream.tready) dv_d = 1'b0;

    case (state_q)
      PASS: begin
        if (in_fire) begin
          dv_d = 1'b1;
          dd_d = upstream.tdata;
          dl_d = upstream.tlast;
          du_d = '0;
          w_d  = (w_q == W_MAX) ? w_q : w_q + 14'd1;
          if (STRADDLE && at_msb) msb_d = upstream.tdata[MSB_LANE*8 +: 8];
          if (at_lsb && !len_valid_q) begin
            len_valid_d = 1'b1;
            end_d       = e_c;
            rem_d       = r_c;
          end
          if (at_end && !upstream.tlast) begin
            // Length reached mid-packet: close it here and drop the padding
            dl_d        = 1'b1;
            du_d        = cur_r;
            trim_inc    = 1'b1;
            state_d     = DROP;
            w_d         = '0;
            len_valid_d = 1'b0;
          end else if (upstream.tlast) begin
            w_d         = '0;
            len_valid_d = 1'b0;
            if (at_end && (cur_r != '0) && (cur_r < n_c)) begin
              du_d     = cur_r;
              trim_inc = 1'b1;
            end else begin
              du_d      = upstream.tuser;
              short_inc = !at_end;
            end
          end
        end
      end
      DROP: begin
        if (in_fire && upstream.tlast) begin
          state_d = PASS;
          w_d     = '0;
        end
      end
      default: state_d = PASS;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PASS;
      w_q         <= '0;
      len_valid_q <= 1'b0;
      end_q       <= '0;
      rem_q       <= '0;
      msb_q       <= '0;
      dv_q        <= 1'b0;
      dd_q        <= '0;
      du_q        <= '0;
      dl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      len_valid_q <= len_valid_d;
      end_q       <= end_d;
      rem_q       <= rem_d;
      msb_q       <= msb_d;
      dv_q        <= dv_d;
      dd_q        <= dd_d;
      du_q        <= du_d;
      dl_q        <= dl_d;
    end
  end

`ifdef AXI4S_TRIM_TO_LENGTH_STATS_EN
  // Saturating per-packet event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trim_count  <= '0;
      short_count <= '0;
    end else begin
      if (trim_inc && (trim_count != 16'hFFFF))   trim_count  <= trim_count + 16'd1;
      if (short_inc && (short_count != 16'hFFFF)) short_count <= short_count + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = trim_inc ^ short_inc;
`endif

endmodule
